// File: rtl/i2c_rx_seq_ctrl.sv
// i2c_rx_seq_ctrl: sequences the 8-bit receive shifter of the I2C slave.
// It generates the bit tick, strobes the shifter 8 times per byte, runs the
// ACK/NACK slot, hands each byte to the consumer over valid/ready, and
// stretches SCL while the consumer still holds the previous byte.
module i2c_rx_seq_ctrl #(
    parameter int DIV   = 4,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    output logic             shift_en,
    output logic             byte_strobe,
    output logic             ack_drive,
    output logic             scl_hold,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    typedef enum logic [1:0] {S_IDLE, S_BIT, S_ACK, S_WAIT} state_t;

    // DIV is at most 255, so an 8-bit divider always suffices
    localparam logic [7:0] DIV_LAST = 8'(DIV - 1);

    state_t           state_q, state_d;
    logic [7:0]       div_cnt_q, div_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic             rx_valid_q, rx_valid_d;
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;

    logic tick;
    logic handshake;
    logic last_byte;

    assign tick      = (div_cnt_q == DIV_LAST);
    assign handshake = rx_valid_q && rx_ready;
    assign last_byte = (remaining_q == LEN_W'(1));

    // state and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            div_cnt_q   <= '0;
            bit_idx_q   <= '0;
            remaining_q <= '0;
            rx_valid_q  <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            bit_idx_q   <= bit_idx_d;
            remaining_q <= remaining_d;
            rx_valid_q  <= rx_valid_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
        end
    end

    // next-state, tick divider, byte counting and strobes
    always_comb begin
        state_d     = state_q;
        div_cnt_d   = div_cnt_q;
        bit_idx_d   = bit_idx_q;
        remaining_d = remaining_q;
        rx_valid_d  = rx_valid_q && !handshake;
        done_d      = 1'b0;
        aborted_d   = 1'b0;
        shift_en    = 1'b0;
        byte_strobe = 1'b0;
        scl_hold    = 1'b0;

        if (state_q != S_IDLE && abort) begin
            // abort wins over a coincident tick: no shift is issued
            state_d     = S_IDLE;
            div_cnt_d   = '0;
            bit_idx_d   = '0;
            remaining_d = '0;
            rx_valid_d  = 1'b0;
            aborted_d   = 1'b1;
            scl_hold    = (state_q == S_WAIT);
        end else begin
            case (state_q)
                S_IDLE: begin
                    div_cnt_d = '0;
                    bit_idx_d = '0;
                    if (start) begin
                        if (len != '0) begin
                            remaining_d = len;
                            state_d     = S_BIT;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                S_BIT: begin
                    div_cnt_d = tick ? 8'd0 : div_cnt_q + 8'd1;
                    if (tick) begin
                        shift_en = 1'b1;
                        if (bit_idx_q == 3'd7) begin
                            byte_strobe = 1'b1;
                            rx_valid_d  = 1'b1;
                            bit_idx_d   = '0;
                            state_d     = S_ACK;
                        end else begin
                            bit_idx_d = bit_idx_q + 3'd1;
                        end
                    end
                end
                S_ACK: begin
                    div_cnt_d = tick ? 8'd0 : div_cnt_q + 8'd1;
                    if (tick) begin
                        if (!rx_valid_q || rx_ready) begin
                            remaining_d = remaining_q - LEN_W'(1);
                            if (last_byte) begin
                                state_d = S_IDLE;
                                done_d  = 1'b1;
                            end else begin
                                state_d = S_BIT;
                            end
                        end else begin
                            // consumer still owns the byte: stretch from this tick on
                            scl_hold = 1'b1;
                            state_d  = S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    scl_hold = 1'b1;
                    if (handshake) begin
                        div_cnt_d   = '0;
                        remaining_d = remaining_q - LEN_W'(1);
                        if (last_byte) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_BIT;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // ACK on every byte but the last, held through any stretch
    assign ack_drive = (state_q == S_ACK || state_q == S_WAIT) && (remaining_q > LEN_W'(1));
    assign busy      = (state_q != S_IDLE);
    assign rx_valid  = rx_valid_q;
    assign done      = done_q;
    assign aborted   = aborted_q;

endmodule

// File: doc/i2c_rx_seq_ctrl.md
Name: i2c_rx_seq_ctrl

Overview:
- Sequences the 8-bit serial-to-parallel receive shifter in the I2C/APB slave datapath.
- Generates the bit tick from the system clock and strobes the shifter's shift enable exactly 8 times per byte.
- Runs the ACK/NACK slot and hands each completed byte to the APB-side consumer over a valid/ready handshake.
- Stretches the bus (holds SCL low) when the consumer has not taken the previous byte; supports multi-byte reads with NACK on the last byte.

Parameters:
- DIV, 4, system clocks per bit tick (legal range 2..255).
- LEN_W, 8, width of the byte-count input.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to begin a receive transaction; ignored while busy
- len  in  LEN_W  number of bytes to receive, sampled on accepted start
- abort  in  1  synchronous abort, acted on in any non-IDLE state
- shift_en  out  1  one-cycle strobe to the external shifter; shifter samples SDA on this cycle
- byte_strobe  out  1  one-cycle pulse on the 8th shift; external shifter output is a complete byte
- ack_drive  out  1  high = pull SDA low (ACK) during the ACK slot
- scl_hold  out  1  high = hold SCL low (clock stretch)
- rx_valid  out  1  byte available to the consumer
- rx_ready  in  1  consumer accepts the byte when rx_valid && rx_ready
- busy  out  1  transaction in progress
- done  out  1  one-cycle pulse when the last byte is accepted and the transaction completes
- aborted  out  1  one-cycle pulse when an abort is taken

Behaviour:
- Reset values: all outputs 0, state IDLE, div_cnt 0, bit_idx 0, remaining 0. Reset mid-transaction returns everything to these values immediately; no done or aborted pulse.
- Tick generation: div_cnt counts 0..DIV-1 and wraps; tick = (div_cnt == DIV-1). div_cnt is cleared on accepted start and frozen in WAIT.
- IDLE:
  - start && len != 0: latch remaining = len, clear bit_idx and div_cnt, busy = 1 from the next cycle, go to BIT.
  - start && len == 0: done pulses the next cycle, busy stays 0, no shifts.
- BIT:
  - On each tick: shift_en = 1 for that cycle and bit_idx increments.
  - On the 8th tick (bit_idx == 7): byte_strobe = 1 in the same cycle, rx_valid rises the next cycle, bit_idx goes to 0, state goes to ACK.
- ACK:
  - ack_drive = 1 for the whole state when remaining > 1. ack_drive = 0 (NACK) when remaining == 1.
  - On the next tick, if the byte has been accepted (rx_valid low, or rx_ready high in that cycle): decrement remaining. If remaining was 1, go to IDLE with done pulsed the next cycle. Otherwise go to BIT.
  - If the byte has not been accepted on that tick: go to WAIT.
- WAIT:
  - scl_hold = 1, ack_drive keeps its ACK-state value, div_cnt frozen.
  - On rx_valid && rx_ready: the next cycle clears scl_hold, decrements remaining and continues as at the end of ACK (BIT, or IDLE with done). div_cnt resumes from 0.
- rx_valid:
  - Stays high until the handshake; dropped the cycle after rx_valid && rx_ready.
  - Never asserted while a previous byte is unaccepted; the stall guarantees this.
- abort: in any non-IDLE state, go to IDLE next cycle, clear rx_valid, scl_hold and ack_drive, pulse aborted, no done. Abort in the same cycle as a tick takes priority over the tick; no shift_en is issued.
- start while busy has no effect. Simultaneous start and abort in IDLE: start is taken.
- remaining wraps nowhere: len is the full count, up to 2^LEN_W - 1 bytes.

Test Plan:
- DIV=4, len=1, rx_ready tied 1, start at cycle 0 -> shift_en at cycles 4, 8, …, 32; byte_strobe at 32; rx_valid at 33; ack_drive = 0 in cycles 33-36; done pulse at 37; busy high cycles 1-36.
- DIV=4, len=3, rx_ready=1 -> 24 shift_en pulses total; ack_drive = 1 after bytes 1 and 2, 0 after byte 3; exactly one done pulse.
- DIV=4, len=2, rx_ready held 0 until 20 cycles after the first byte_strobe -> scl_hold = 1 from the first ACK-slot tick until 1 cycle after the handshake; no shift_en during the stall; second byte proceeds normally.
- abort asserted at the 5th shift_en tick of byte 1 -> no shift_en that cycle; aborted pulse next cycle; busy = 0, rx_valid = 0, no done.
- start with len=0 -> done pulse the next cycle; shift_en never asserted; busy stays 0.
- rst_n pulsed low mid-byte (after the 3rd shift_en) -> all outputs 0 asynchronously; a new start after release produces the full 8 shifts from bit 0.
